// File: rtl/codificador_pkg.sv
// Shared constants and state encoding for the priority encoder slice.
package codificador_pkg;
  localparam int N = 8;
  localparam int W = 3;

  typedef enum logic {IDLE, OFFER} state_t;
endpackage

// File: rtl/buscador_prioridad.sv
// Upward wrap-around search: first set bit of vector at or above start, wrapping 7->0.
module buscador_prioridad
  import codificador_pkg::*;
(
  input  logic [N-1:0] vector,
  input  logic [W-1:0] start,
  output logic [W-1:0] index,
  output logic         found
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [W-1:0]   w_off;

  // Rotating right by start turns the wrap search into a plain lowest-bit search.
  assign w_dbl = {vector, vector} >> start;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = W'(i);
    end
  end

  assign found = |vector;
  assign index = start + w_off;

endmodule

// File: rtl/decodificador.sv
// 3-to-8 decoder with enable; the encoder uses it to build the acceptance mask.
module decodificador
  import codificador_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic         i_en,
  output logic [N-1:0] o_y
);

  always_comb begin
    o_y = '0;
    if (i_en) o_y[i_a] = 1'b1;
  end

endmodule

// File: rtl/codificador_prioridad.sv
// 8-to-3 priority encoder with pending-request register, handshake and fixed/round-robin selection.
module codificador_prioridad
  import codificador_pkg::*;
#(
  parameter int RR = 0
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         clr,
  input  logic         ready,
  output logic [W-1:0] a,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic         ovf
);

  state_t       r_state, w_state_next;
  logic [W-1:0] r_a, w_a_next;
  logic [W-1:0] r_last;
  logic [N-1:0] r_pend;
  logic         r_ovf;

  logic         w_acc;
  logic [N-1:0] w_acc_mask;
  logic [N-1:0] w_pend_next;
  logic [W-1:0] w_last_eff;
  logic [W-1:0] w_start;
  logic [W-1:0] w_sel;
  logic         w_found;

  assign w_acc = (r_state == OFFER) && ready;

  decodificador u_dec (
    .i_a  (r_a),
    .i_en (w_acc),
    .o_y  (w_acc_mask)
  );

  assign w_pend_next = (r_pend & ~w_acc_mask) | req;

  // An index accepted this cycle already counts as last_accepted for the next search.
  assign w_last_eff = w_acc ? r_a : r_last;
  assign w_start    = (RR != 0) ? w_last_eff + W'(1) : '0;

  buscador_prioridad u_bus (
    .vector (w_pend_next),
    .start  (w_start),
    .index  (w_sel),
    .found  (w_found)
  );

  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_next = OFFER;
          w_a_next     = w_sel;
        end
      end
      OFFER: begin
        if (ready) begin
          if (w_found) w_a_next = w_sel;
          else         w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_last  <= W'(N - 1);
    end else if (clr) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_a     <= w_a_next;
      r_pend  <= w_pend_next;
      if (w_acc) r_last <= r_a;
      if (|(req & r_pend & ~w_acc_mask)) r_ovf <= 1'b1;
    end
  end

  assign a     = r_a;
  assign valid = (r_state == OFFER);
  assign pend  = r_pend;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_codificador_prioridad.sv
// Bench for codificador_prioridad: fixed and round-robin instances against a behavioural model.
module tb_codificador_prioridad;

  logic       clk = 1'b0;
  logic       rst_n, clr, ready;
  logic [7:0] req;

  logic [2:0] d_a   [2];
  logic       d_v   [2];
  logic [7:0] d_pend[2];
  logic       d_ovf [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [7:0] m_pend[2];
  int         m_a   [2];
  bit         m_v   [2];
  bit         m_ovf [2];
  int         m_last[2];

  always #5 clk = ~clk;

  codificador_prioridad #(.RR(0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .clr(clr), .ready(ready),
    .a(d_a[0]), .valid(d_v[0]), .pend(d_pend[0]), .ovf(d_ovf[0])
  );

  codificador_prioridad #(.RR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .clr(clr), .ready(ready),
    .a(d_a[1]), .valid(d_v[1]), .pend(d_pend[1]), .ovf(d_ovf[1])
  );

  function automatic int pick(input logic [7:0] vec, input int s);
    for (int j = 0; j < 8; j++) begin
      if (vec[(s + j) % 8]) return (s + j) % 8;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: spec rules applied at every rising edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_pend[k] = 8'h00; m_a[k] = 0; m_v[k] = 0; m_ovf[k] = 0; m_last[k] = 7;
      end else if (clr) begin
        m_pend[k] = 8'h00; m_v[k] = 0; m_ovf[k] = 0;
      end else begin
        logic [7:0] acc_bits;
        logic [7:0] nxt;
        bit         acc;
        acc      = m_v[k] && ready;
        acc_bits = 8'h00;
        if (acc) acc_bits[m_a[k]] = 1'b1;
        for (int i = 0; i < 8; i++)
          if (req[i] && m_pend[k][i] && !acc_bits[i]) m_ovf[k] = 1;
        nxt = (m_pend[k] & ~acc_bits) | req;
        if (acc) m_last[k] = m_a[k];
        if (!m_v[k] || ready) begin
          if (nxt != 8'h00) begin
            m_v[k] = 1;
            m_a[k] = pick(nxt, (k == 1) ? (m_last[k] + 1) % 8 : 0);
          end else begin
            m_v[k] = 0;
          end
        end
        m_pend[k] = nxt;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cmp_valid[%0d]", k), int'(d_v[k]), int'(m_v[k]));
        chk($sformatf("cmp_pend[%0d]", k), int'(d_pend[k]), int'(m_pend[k]));
        chk($sformatf("cmp_ovf[%0d]", k), int'(d_ovf[k]), int'(m_ovf[k]));
        if (m_v[k]) chk($sformatf("cmp_a[%0d]", k), int'(d_a[k]), m_a[k]);
      end
    end
  end

  task automatic step(input logic [7:0] r, input logic c, input logic rd, input logic rn);
    req = r; clr = c; ready = rd; rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    req = 8'h00; clr = 1'b0; ready = 1'b0; rst_n = 1'b0;

    chk("model_pick_fix", pick(8'hA4, 0), 2);
    chk("model_pick_wrap", pick(8'h81, 1), 7);

    step(8'h00, 0, 0, 0);
    step(8'h00, 0, 0, 0);
    cmp_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_a", int'(d_a[k]), 0);
      chk("rst_valid", int'(d_v[k]), 0);
      chk("rst_pend", int'(d_pend[k]), 0);
      chk("rst_ovf", int'(d_ovf[k]), 0);
    end

    // Fixed priority drain of 1010_0100
    step(8'hA4, 0, 1, 1); chk("fix_a0", int'(d_a[0]), 2); chk("fix_v0", int'(d_v[0]), 1);
    step(8'h00, 0, 1, 1); chk("fix_a1", int'(d_a[0]), 5);
    step(8'h00, 0, 1, 1); chk("fix_a2", int'(d_a[0]), 7);
    step(8'h00, 0, 1, 1); chk("fix_vend", int'(d_v[0]), 0); chk("fix_pend", int'(d_pend[0]), 0);

    // Offer held while ready is low
    step(8'h10, 0, 0, 1); chk("hold_a", int'(d_a[0]), 4); chk("hold_v", int'(d_v[0]), 1);
    step(8'h01, 0, 0, 1); chk("hold_a1", int'(d_a[0]), 4);
    step(8'h00, 0, 0, 1); chk("hold_a2", int'(d_a[0]), 4);
    step(8'h00, 0, 1, 1); chk("hold_next", int'(d_a[0]), 0); chk("hold_nv", int'(d_v[0]), 1);
    step(8'h00, 0, 1, 1); chk("hold_idle", int'(d_v[0]), 0);

    // Overflow and clear
    step(8'h08, 0, 0, 1); chk("ovf_first", int'(d_ovf[0]), 0);
    step(8'h08, 0, 0, 1); chk("ovf_set", int'(d_ovf[0]), 1);
    step(8'h00, 1, 1, 1);
    chk("clr_ovf", int'(d_ovf[0]), 0); chk("clr_pend", int'(d_pend[0]), 0); chk("clr_v", int'(d_v[0]), 0);

    // Re-request on the index being accepted
    step(8'h08, 0, 0, 1); chk("sim_a", int'(d_a[0]), 3);
    step(8'h08, 0, 1, 1);
    chk("sim_pend", int'(d_pend[0]), 8'h08); chk("sim_ovf", int'(d_ovf[0]), 0);
    chk("sim_a2", int'(d_a[0]), 3); chk("sim_v", int'(d_v[0]), 1);
    chk("sim_rr_a", int'(d_a[1]), 3);
    step(8'h00, 1, 0, 1);

    // Round-robin sweep and wrap
    step(8'h00, 0, 0, 0);
    step(8'hFF, 0, 1, 1); chk("rr_a0", int'(d_a[1]), 0);
    for (int i = 1; i < 8; i++) begin
      step(8'h00, 0, 1, 1);
      chk($sformatf("rr_a%0d", i), int'(d_a[1]), i);
    end
    step(8'h00, 0, 1, 1); chk("rr_idle", int'(d_v[1]), 0);
    step(8'h01, 0, 1, 1); chk("rr_one", int'(d_a[1]), 0);
    step(8'h00, 0, 1, 1);
    step(8'h81, 0, 0, 1); chk("rr_wrap7", int'(d_a[1]), 7);
    step(8'h00, 0, 1, 1); chk("rr_wrap0", int'(d_a[1]), 0);
    step(8'h00, 0, 1, 1);

    // Reset in the middle of an offer
    step(8'hF0, 0, 0, 1); chk("mid_v", int'(d_v[1]), 1); chk("mid_pend", int'(d_pend[1]), 8'hF0);
    step(8'h00, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      chk("mrst_a", int'(d_a[k]), 0); chk("mrst_v", int'(d_v[k]), 0);
      chk("mrst_pend", int'(d_pend[k]), 0); chk("mrst_ovf", int'(d_ovf[k]), 0);
    end
    step(8'hFF, 0, 0, 1); chk("mrst_rr_first", int'(d_a[1]), 0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] r;
      r = 8'h00;
      for (int b = 0; b < 8; b++) if ($urandom_range(5) == 0) r[b] = 1'b1;
      step(r, ($urandom_range(40) == 0), ($urandom_range(2) != 0), ($urandom_range(150) != 0));
    end

    step(8'h00, 0, 0, 1);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
